// File: rtl/bitrev_buffer_ram_if.sv
// Controller bus and host fill/drain stream bundle for bitrev_buffer_ram.
// master = controller/host side, slave = buffer RAM.
interface bitrev_buffer_ram_if #(
    parameter int LANES  = 2,
    parameter int WORD_W = 8,
    parameter int ADDR_W = 4
);
    localparam int W = LANES * WORD_W;

    typedef struct packed {
        logic [ADDR_W-1:0] raddr;
        logic [ADDR_W-1:0] waddr;
        logic              wren;
        logic [W-1:0]      wdata;
    } ram_inputs_t;

    ram_inputs_t  ram_inputs;
    logic [W-1:0] ram_outputs_rdata;
    logic         ctrl_active;
    logic         fill_start;
    logic         drain_start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         err;

    modport master (
        output ram_inputs, ctrl_active, fill_start, drain_start, in_valid, in_data, out_ready,
        input  ram_outputs_rdata, in_ready, out_valid, out_data, out_last, busy, err
    );

    modport slave (
        input  ram_inputs, ctrl_active, fill_start, drain_start, in_valid, in_data, out_ready,
        output ram_outputs_rdata, in_ready, out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/bitrev_buffer_ram.sv
// Slice buffer RAM: fixed-latency controller read/write port plus host fill/drain streams.
// Define BITREV_RAM_FWD_EN for write-first on same-address controller read/write (default read-first).
module bitrev_buffer_ram #(
    parameter int LANES  = 2,
    parameter int WORD_W = 8,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 2
) (
    input logic                clk,
    input logic                rstn,
    bitrev_buffer_ram_if.slave bus
);
    localparam int W     = LANES * WORD_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FD    = RD_LAT + 1;
    localparam int PW    = $clog2(FD);
    localparam int CW    = $clog2(2 * FD + 1) + 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DRAIN_FLUSH} state_t;

    state_t            state_q;
    logic              in_ready_q, busy_q, err_q;
    logic [ADDR_W-1:0] fcnt_q, dcnt_q;
    logic [W-1:0]      rdata_q;
    logic [W-1:0]      mem_q [DEPTH];

    logic [W-1:0]      fifo_data_q [FD];
    logic [FD-1:0]     fifo_last_q;
    logic [PW-1:0]     wp_q, rp_q;
    logic [CW-1:0]     occ_q, inflight;

    logic              is_idle, fill_hs, issue, pop, head_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, rd_addr;
    logic [W-1:0]      mem_wdata, raw_data, fin_data;
    logic              rd_c, rd_d, rd_last, fin_c, fin_d, fin_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_idle   = (state_q == IDLE);
    assign fill_hs   = (state_q == FILL) && bus.in_valid && in_ready_q;
    // Throttle issue so every in-flight word has a FIFO slot even if out_ready stays low.
    assign issue     = (state_q == DRAIN) && ((occ_q + inflight) < CW'(FD));
    assign pop       = (occ_q != '0) && bus.out_ready;
    assign head_last = fifo_last_q[rp_q];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.ram_inputs.waddr;
        mem_wdata = bus.ram_inputs.wdata;
        if (is_idle) begin
            mem_we = bus.ram_inputs.wren;
        end else if (fill_hs) begin
            mem_we    = 1'b1;
            mem_waddr = fcnt_q;
            mem_wdata = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign rd_addr = is_idle ? bus.ram_inputs.raddr : dcnt_q;
    assign rd_c    = is_idle;
    assign rd_d    = issue;
    assign rd_last = (dcnt_q == '1);

`ifdef BITREV_RAM_FWD_EN
    assign raw_data = (is_idle && bus.ram_inputs.wren && (bus.ram_inputs.raddr == bus.ram_inputs.waddr))
                      ? bus.ram_inputs.wdata : mem_q[rd_addr];
`else
    assign raw_data = mem_q[rd_addr];
`endif

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign fin_data = raw_data;
            assign fin_c    = rd_c;
            assign fin_d    = rd_d;
            assign fin_last = rd_last;
            assign inflight = '0;
        end else begin : g_pipe
            logic [W-1:0]      data_q [RD_LAT-1];
            logic [RD_LAT-2:0] c_q, d_q, l_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    c_q <= '0;
                    d_q <= '0;
                    l_q <= '0;
                end else begin
                    c_q[0] <= rd_c;
                    d_q[0] <= rd_d;
                    l_q[0] <= rd_last;
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        c_q[k] <= c_q[k-1];
                        d_q[k] <= d_q[k-1];
                        l_q[k] <= l_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                data_q[0] <= raw_data;
                for (int k = 1; k < RD_LAT - 1; k++) data_q[k] <= data_q[k-1];
            end

            always_comb begin
                inflight = '0;
                for (int k = 0; k < RD_LAT - 1; k++) inflight = inflight + CW'(d_q[k]);
            end

            assign fin_data = data_q[RD_LAT-2];
            assign fin_c    = c_q[RD_LAT-2];
            assign fin_d    = d_q[RD_LAT-2];
            assign fin_last = l_q[RD_LAT-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rdata_q <= '0;
        else if (fin_c && is_idle) rdata_q <= fin_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < FD; k++) fifo_data_q[k] <= '0;
            fifo_last_q <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            occ_q       <= '0;
        end else begin
            if (fin_d) begin
                fifo_data_q[wp_q] <= fin_data;
                fifo_last_q[wp_q] <= fin_last;
                wp_q              <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            occ_q <= occ_q + CW'(fin_d) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((bus.fill_start || bus.drain_start) && bus.ctrl_active) err_q <= 1'b1;
                    if (bus.fill_start && !bus.ctrl_active) begin
                        state_q    <= FILL;
                        fcnt_q     <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (bus.drain_start && !bus.ctrl_active) begin
                        state_q <= DRAIN;
                        dcnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (fill_hs) begin
                        fcnt_q <= fcnt_q + 1'b1;
                        if (fcnt_q == '1) begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        dcnt_q <= dcnt_q + 1'b1;
                        if (dcnt_q == '1) state_q <= DRAIN_FLUSH;
                    end
                end
                DRAIN_FLUSH: begin
                    if (pop && head_last) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (!is_idle && (bus.ram_inputs.wren || bus.ctrl_active || bus.fill_start || bus.drain_start))
                err_q <= 1'b1;
        end
    end

    assign bus.ram_outputs_rdata = rdata_q;
    assign bus.in_ready          = in_ready_q;
    assign bus.out_valid         = (occ_q != '0);
    assign bus.out_data          = fifo_data_q[rp_q];
    assign bus.out_last          = (occ_q != '0) && head_last;
    assign bus.busy              = busy_q;
    assign bus.err               = err_q;
endmodule
